// File: rtl/timer_bank_if.sv
// Register-bus interface for timer_bank: write strobe, channel/register select, write and read data.
interface timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic [CNT_W-1:0] wr_data;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output wr_en, ch_sel, reg_sel, wr_data,
    input  rd_data
  );

  modport slave (
    input  wr_en, ch_sel, reg_sel, wr_data,
    output rd_data
  );
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_CH prescaled down-counters with one-shot / auto-reload / PWM modes and sticky IRQs.
// Define TIMER_BANK_PWM_EN to build PWM mode and the per-channel CMP registers.
module timer_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  timer_bank_if.slave       bus,
  output logic [NUM_CH-1:0] cnt_out,
  output logic [NUM_CH-1:0] irq_pend,
  output logic              irq
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CTRL_W = PRESC_W + 4;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  logic [NUM_CH-1:0][CNT_W-1:0] count_all;
  logic [NUM_CH-1:0]            term_vec;
  logic [NUM_CH-1:0]            ien_vec;
  logic [NUM_CH-1:0]            clr_mask;
  logic [CTRL_W-1:0]            ctrl_wdata;

  assign ctrl_wdata = CTRL_W'(bus.wr_data);
  assign clr_mask   = (bus.wr_en && (bus.reg_sel == 2'd3)) ? NUM_CH'(bus.wr_data) : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   reload_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [PRESC_W-1:0] presc_q;
    logic               out_q;
    logic               sel, load_wr, ctrl_wr, tick, term;
    logic               is_pwm, is_reload, is_oneshot, pwm_level;
    mode_e              mode;

    assign sel     = bus.wr_en && (bus.ch_sel == CH_W'(i));
    assign load_wr = sel && (bus.reg_sel == 2'd0);
    assign ctrl_wr = sel && (bus.reg_sel == 2'd1);
    assign mode    = mode_e'(ctrl_q[2:1]);

    // A LOAD or CTRL write restarts the prescaler and swallows any tick due in the same cycle.
    assign tick = ctrl_q[0] && (presc_q == ctrl_q[CTRL_W-1:4]) && !load_wr && !ctrl_wr;
    assign term = tick && (count_q == '0);

`ifdef TIMER_BANK_PWM_EN
    logic [CNT_W-1:0] cmp_q;

    assign is_pwm    = (mode == MODE_PWM);
    assign is_reload = (mode == MODE_RELOAD);
    assign pwm_level = (count_q < cmp_q);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cmp_q <= '0;
      end else if (sel && (bus.reg_sel == 2'd2)) begin
        cmp_q <= bus.wr_data;
      end
    end
`else
    assign is_pwm    = 1'b0;
    assign is_reload = (mode == MODE_RELOAD) || (mode == MODE_PWM);
    assign pwm_level = 1'b0;
`endif

    assign is_oneshot = !is_pwm && !is_reload;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        count_q  <= '0;
        reload_q <= '0;
        ctrl_q   <= '0;
        presc_q  <= '0;
        out_q    <= 1'b0;
      end else begin
        if (load_wr || ctrl_wr) begin
          presc_q <= '0;
        end else if (ctrl_q[0]) begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
        end

        if (load_wr) begin
          count_q  <= bus.wr_data;
          reload_q <= bus.wr_data;
        end else if (term) begin
          if (!is_oneshot) begin
            count_q <= reload_q;
          end
        end else if (tick) begin
          count_q <= count_q - 1'b1;
        end

        if (ctrl_wr) begin
          ctrl_q <= ctrl_wdata;
        end else if (term && is_oneshot) begin
          ctrl_q[0] <= 1'b0;
        end

        // PWM output follows the compare every cycle; the other modes only move on events.
        if (is_pwm) begin
          out_q <= pwm_level;
        end else if (load_wr && is_oneshot) begin
          out_q <= 1'b0;
        end else if (term) begin
          out_q <= is_oneshot ? 1'b1 : !out_q;
        end
      end
    end

    assign count_all[i] = count_q;
    assign term_vec[i]  = term;
    assign ien_vec[i]   = ctrl_q[3];
    assign cnt_out[i]   = out_q;
  end

  // A terminal event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_pend <= '0;
    end else begin
      irq_pend <= (irq_pend & ~clr_mask) | term_vec;
    end
  end

  assign irq = |(irq_pend & ien_vec);

  always_comb begin
    bus.rd_data = '0;
    if ({1'b0, bus.ch_sel} < (CH_W + 1)'(NUM_CH)) begin
      bus.rd_data = count_all[bus.ch_sel];
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (NUM_CH=4, CNT_W=32, PRESC_W=8).
module tb_timer_bank;
  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  timer_bank_if #(.NUM_CH(4), .CNT_W(32)) bus ();

  timer_bank #(.NUM_CH(4), .CNT_W(32), .PRESC_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .cnt_out  (),
    .irq_pend (),
    .irq      ()
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the next rising edge and we return on the falling edge after it.
  task automatic applyStimulus(input logic [1:0] ch, input logic [1:0] rs, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.ch_sel  = ch;
    bus.reg_sel = rs;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    bus.wr_en   = 1'b0;
    bus.ch_sel  = 2'd0;
    bus.reg_sel = 2'd0;
    bus.wr_data = '0;

    idle(2);
    checkOutput("rst_rd", bus.rd_data, 32'd0);
    checkOutput("rst_cnt_out", {28'd0, dut.cnt_out}, 32'h0);
    checkOutput("rst_pend", {28'd0, dut.irq_pend}, 32'h0);
    checkOutput("rst_irq", {31'd0, dut.irq}, 32'h0);
    rstn = 1'b1;
    idle(1);

    // ch0 one-shot, LOAD=3, P=0: terminal four clocks after the enabling write
    applyStimulus(2'd0, 2'd0, 32'd3);
    checkOutput("os_load", bus.rd_data, 32'd3);
    applyStimulus(2'd0, 2'd1, 32'h1);
    checkOutput("os_en_edge", bus.rd_data, 32'd3);
    idle(1);
    checkOutput("os_cnt2", bus.rd_data, 32'd2);
    idle(2);
    checkOutput("os_cnt0", bus.rd_data, 32'd0);
    checkOutput("os_pend_early", {28'd0, dut.irq_pend}, 32'h0);
    idle(1);
    checkOutput("os_pend", {28'd0, dut.irq_pend}, 32'h1);
    checkOutput("os_out", {28'd0, dut.cnt_out}, 32'h1);
    checkOutput("os_irq_off", {31'd0, dut.irq}, 32'h0);
    applyStimulus(2'd3, 2'd3, 32'h1);
    idle(3);
    checkOutput("os_en_cleared", {28'd0, dut.irq_pend}, 32'h0);
    checkOutput("os_out_sticky", {28'd0, dut.cnt_out}, 32'h1);
    applyStimulus(2'd0, 2'd0, 32'd5);
    checkOutput("os_out_cleared", {28'd0, dut.cnt_out}, 32'h0);

    // ch1 auto-reload, LOAD=1, P=1: terminal every 4 clocks
    applyStimulus(2'd1, 2'd0, 32'd1);
    applyStimulus(2'd1, 2'd1, 32'h13);
    idle(3);
    checkOutput("ar_cnt0", bus.rd_data, 32'd0);
    checkOutput("ar_out_pre", {28'd0, dut.cnt_out}, 32'h0);
    idle(1);
    checkOutput("ar_out_t1", {28'd0, dut.cnt_out}, 32'h2);
    checkOutput("ar_pend", {28'd0, dut.irq_pend}, 32'h2);
    checkOutput("ar_reload", bus.rd_data, 32'd1);
    checkOutput("ar_irq_off", {31'd0, dut.irq}, 32'h0);
    idle(3);
    checkOutput("ar_out_mid", {28'd0, dut.cnt_out}, 32'h2);
    idle(1);
    checkOutput("ar_out_t2", {28'd0, dut.cnt_out}, 32'h0);
    applyStimulus(2'd1, 2'd1, 32'h1B);
    checkOutput("ar_irq_on", {31'd0, dut.irq}, 32'h1);
    applyStimulus(2'd1, 2'd3, 32'h2);
    checkOutput("ar_clr_pend", {28'd0, dut.irq_pend}, 32'h0);
    checkOutput("ar_clr_irq", {31'd0, dut.irq}, 32'h0);
    applyStimulus(2'd1, 2'd1, 32'h0);

`ifdef TIMER_BANK_PWM_EN
    // ch2 PWM, LOAD=9, CMP=3, P=0: high for counts 2,1,0 of each 10-clock period
    applyStimulus(2'd2, 2'd0, 32'd9);
    applyStimulus(2'd2, 2'd2, 32'd3);
    applyStimulus(2'd2, 2'd1, 32'h5);
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      checkOutput($sformatf("pwm_k%0d", k), {31'd0, dut.cnt_out[2]},
                  {31'd0, ((k % 10) == 8) || ((k % 10) == 9) || ((k % 10) == 0)});
    end
    checkOutput("pwm_pend", {28'd0, dut.irq_pend}, 32'h4);
`else
    // without PWM support mode 10 runs as auto-reload and CMP writes are dropped
    applyStimulus(2'd2, 2'd0, 32'd2);
    applyStimulus(2'd2, 2'd2, 32'd3);
    applyStimulus(2'd2, 2'd1, 32'h5);
    idle(2);
    checkOutput("m10_out_pre", {28'd0, dut.cnt_out}, 32'h0);
    checkOutput("m10_cnt0", bus.rd_data, 32'd0);
    idle(1);
    checkOutput("m10_out_t1", {28'd0, dut.cnt_out}, 32'h4);
    checkOutput("m10_pend", {28'd0, dut.irq_pend}, 32'h4);
    checkOutput("m10_reload", bus.rd_data, 32'd2);
    idle(3);
    checkOutput("m10_out_t2", {28'd0, dut.cnt_out}, 32'h0);
`endif
    applyStimulus(2'd2, 2'd1, 32'h0);
    applyStimulus(2'd2, 2'd3, 32'h4);
    checkOutput("ch2_clr", {28'd0, dut.irq_pend}, 32'h0);

    // ch3 terminal coincides with IRQ_CLR of the same bit; upper CTRL bits are truncated away
    applyStimulus(2'd3, 2'd0, 32'd2);
    applyStimulus(2'd3, 2'd1, 32'hFFFF_0001);
    idle(2);
    checkOutput("coll_cnt0", bus.rd_data, 32'd0);
    applyStimulus(2'd3, 2'd3, 32'h8);
    checkOutput("coll_set_wins", {28'd0, dut.irq_pend}, 32'h8);
    checkOutput("coll_out", {28'd0, dut.cnt_out}, 32'h8);
    applyStimulus(2'd0, 2'd3, 32'h8);
    checkOutput("coll_later_clr", {28'd0, dut.irq_pend}, 32'h0);

    // ch2 one-shot from zero with irq-enable: immediate terminal
    applyStimulus(2'd2, 2'd0, 32'd0);
    applyStimulus(2'd2, 2'd1, 32'h9);
    idle(1);
    checkOutput("z_pend", {28'd0, dut.irq_pend}, 32'h4);
    checkOutput("z_out", {28'd0, dut.cnt_out}, 32'hC);
    checkOutput("z_irq", {31'd0, dut.irq}, 32'h1);

    // LOAD on ch0 in the cycle it would hit its terminal tick
    applyStimulus(2'd0, 2'd0, 32'd1);
    applyStimulus(2'd0, 2'd1, 32'h1);
    idle(1);
    checkOutput("lw_cnt0", bus.rd_data, 32'd0);
    applyStimulus(2'd0, 2'd0, 32'd7);
    checkOutput("lw_count", bus.rd_data, 32'd7);
    checkOutput("lw_no_pend", {28'd0, dut.irq_pend}, 32'h4);
    checkOutput("lw_out", {28'd0, dut.cnt_out}, 32'hC);
    idle(1);
    checkOutput("lw_cnt6", bus.rd_data, 32'd6);
    idle(1);
    checkOutput("lw_cnt5", bus.rd_data, 32'd5);

    // asynchronous reset mid-count
    rstn = 1'b0;
    #1;
    checkOutput("ar_rst_out", {28'd0, dut.cnt_out}, 32'h0);
    checkOutput("ar_rst_pend", {28'd0, dut.irq_pend}, 32'h0);
    checkOutput("ar_rst_irq", {31'd0, dut.irq}, 32'h0);
    checkOutput("ar_rst_rd", bus.rd_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(3);
    checkOutput("post_rst_rd", bus.rd_data, 32'd0);
    checkOutput("post_rst_pend", {28'd0, dut.irq_pend}, 32'h0);
    checkOutput("post_rst_out", {28'd0, dut.cnt_out}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, counter/reload width in bits (8..32).
REQ-003 The block SHALL have parameter PRESC_W, default 8, prescaler width in bits.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-007 The block SHALL have port ch_sel  input  max(1,clog2(NUM_CH))  target channel for write/read.
REQ-008 The block SHALL have port reg_sel  input  2  0=LOAD, 1=CTRL, 2=CMP, 3=IRQ_CLR.
REQ-009 The block SHALL have port wr_data  input  CNT_W  write data.
REQ-010 The block SHALL have port rd_data  output  CNT_W  current count of ch_sel, combinational from registers.
REQ-011 The block SHALL have port cnt_out  output  NUM_CH  per-channel timer output, registered.
REQ-012 The block SHALL have port irq_pend  output  NUM_CH  per-channel sticky terminal flags.
REQ-013 The block SHALL have port irq  output  1  OR over channels of irq_pend & irq-enable.

Function
REQ-014 CTRL layout SHALL be [0] enable, [2:1] mode (00 one-shot, 01 auto-reload, 10 PWM, 11 treated as one-shot), [3] irq-enable, [PRESC_W+3:4] prescale P.
REQ-015 An enabled channel SHALL generate a tick once every P+1 clocks; its prescaler counts 0..P, restarting at 0 on any LOAD or CTRL write and whenever enable goes 0->1.
REQ-016 On a tick with count != 0 the count SHALL decrement by 1; a disabled channel SHALL hold count and prescaler.
REQ-017 On a tick with count == 0 (terminal event) irq_pend[ch] SHALL be set, visible the following cycle.
REQ-018 One-shot terminal: count stays 0, enable clears, cnt_out[ch] goes 1 and stays 1 until the next LOAD write.
REQ-019 Auto-reload terminal: count reloads from the reload register, cnt_out[ch] toggles.
REQ-020 PWM terminal: count reloads; cnt_out[ch] SHALL equal (count < CMP) every cycle, registered.
REQ-021 A LOAD write SHALL set both reload register and count to wr_data, and clear a one-shot cnt_out.
REQ-022 An IRQ_CLR write SHALL clear irq_pend bits where wr_data is 1 (ch_sel ignored).
REQ-023 Terminal event and IRQ_CLR on the same bit in one cycle: set SHALL win.
REQ-024 LOAD write and tick on the same channel in one cycle: the write SHALL win for count; no terminal event that cycle.
REQ-025 Write data wider than a field SHALL be truncated; ch_sel >= NUM_CH writes SHALL be ignored and rd_data SHALL read 0.

Reset
REQ-026 On rstn low, all counts, reload, CMP, CTRL, prescalers, cnt_out, irq_pend SHALL clear to 0 asynchronously; irq SHALL be 0.
REQ-027 Reset deassertion mid-count SHALL restart from the cleared state; no pending event survives.

Configuration
REQ-028 With TIMER_BANK_PWM_EN defined, PWM mode and CMP registers SHALL exist as in REQ-020.
REQ-029 Without TIMER_BANK_PWM_EN, mode 10 SHALL behave as auto-reload, CMP writes SHALL be ignored, and no CMP storage SHALL be built.

Verification
REQ-030 NUM_CH=4: LOAD ch0=3, CTRL ch0 enable, one-shot, P=0 -> terminal 4 clocks later, irq_pend=0001, cnt_out[0]=1, enable cleared.
REQ-031 Auto-reload ch1, LOAD=1, P=1 -> terminal every 4 clocks, cnt_out[1] toggles each terminal, irq=1 only with irq-enable set.
REQ-032 PWM ch2 (TIMER_BANK_PWM_EN), LOAD=9, CMP=3, P=0 -> cnt_out[2] high 3 of every 10 clocks.
REQ-033 Terminal on ch3 in same cycle as IRQ_CLR wr_data=1000 -> irq_pend[3]=1 afterwards; a later IRQ_CLR clears it.
REQ-034 rstn pulsed low while ch0 counting at count 5 -> all outputs 0 immediately, rd_data=0 after release.
REQ-035 LOAD ch0=7 in the cycle ch0 ticks at count 0 -> count=7, no irq_pend set.
